// File: rtl/multi_lane_rate_recovery_if.sv
// rtl/multi_lane_rate_recovery_if.sv - configuration, edge strobes and per-lane results of the rate recovery block
interface multi_lane_rate_recovery_if #(
  parameter int CHANNELS = 2,
  parameter int COUNT_W  = 16,
  parameter int TOL_W    = 8
);
  logic                        enable_i;
  logic                        clear_state_i;
  logic [2:0]                  mode_i;
  logic [1:0]                  polarity_i;
  logic [TOL_W-1:0]            tolerance_i;
  logic [COUNT_W-1:0]          pause_timeout_i;
  logic [CHANNELS-1:0]         rising_edge_i;
  logic [CHANNELS-1:0]         falling_edge_i;
  logic [CHANNELS*COUNT_W-1:0] rate_o;
  logic [CHANNELS-1:0]         locked_o;
  logic [CHANNELS-1:0]         paused_o;
  logic [CHANNELS-1:0]         violation_o;
  logic [CHANNELS-1:0]         drift_o;
  logic [CHANNELS-1:0]         drift_dir_o;

  modport master (
    output enable_i, clear_state_i, mode_i, polarity_i, tolerance_i, pause_timeout_i,
    output rising_edge_i, falling_edge_i,
    input  rate_o, locked_o, paused_o, violation_o, drift_o, drift_dir_o
  );

  modport slave (
    input  enable_i, clear_state_i, mode_i, polarity_i, tolerance_i, pause_timeout_i,
    input  rising_edge_i, falling_edge_i,
    output rate_o, locked_o, paused_o, violation_o, drift_o, drift_dir_o
  );
endinterface

// File: rtl/multi_lane_rate_recovery.sv
// rtl/multi_lane_rate_recovery.sv - per-lane edge-interval rate recovery with lock, drift tracking and pause
module multi_lane_rate_recovery #(
  parameter int CHANNELS   = 2,
  parameter int COUNT_W    = 16,
  parameter int TOL_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input logic                        clk_i,
  input logic                        rst_n_i,
  multi_lane_rate_recovery_if.slave  bus_if
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX    = {COUNT_W{1'b1}};
  localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);

  logic [1:0]         kind;
  logic               pausable;
  logic               clear_req;
  logic               kind_half;
  logic               split_pos;
  logic               split_neg;
  logic               timeout_en;
  logic [COUNT_W-1:0] tol_ext;

  // Shared mode decode: all lanes see the same configuration every cycle
  always_comb begin
    kind       = bus_if.mode_i[1:0];
    pausable   = bus_if.mode_i[2];
    clear_req  = bus_if.clear_state_i || !bus_if.enable_i;
    kind_half  = (kind == 2'b01) || (kind == 2'b10);
    split_pos  = (bus_if.polarity_i == 2'b01) && (kind != 2'b10);
    split_neg  = (bus_if.polarity_i == 2'b10) && (kind != 2'b10);
    tol_ext    = COUNT_W'(bus_if.tolerance_i);
    timeout_en = (bus_if.pause_timeout_i != '0);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    state_t             state_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;
    logic [COUNT_W-1:0] cand_q;
    logic [COUNT_W-1:0] rate_q;
    logic [MATCH_W-1:0] match_q;
    logic               cand_valid_q;
    logic               locked_q;
    logic               paused_q;
    logic               viol_q;
    logic               drift_q;
    logic               dir_q;

    logic               rise;
    logic               fall;
    logic               any_evt;
    logic               start_evt;
    logic               update_evt;
    logic               saturated;
    logic [COUNT_W-1:0] measured;
    logic [COUNT_W-1:0] half;
    logic [COUNT_W-1:0] norm;
    logic [COUNT_W-1:0] cand_diff;
    logic [COUNT_W-1:0] rate_diff;
    logic [COUNT_W:0]   norm_x2;
    logic               rate_up;
    logic               cand_ok;
    logic               rate_ok;
    logic               fast_relock;
    logic               timeout_hit;

    // Event qualification, interval measurement and tolerance comparisons
    always_comb begin
      rise        = bus_if.rising_edge_i[g];
      fall        = bus_if.falling_edge_i[g];
      any_evt     = rise | fall;
      start_evt   = split_pos ? rise : (split_neg ? fall : any_evt);
      update_evt  = split_pos ? fall : (split_neg ? rise : any_evt);
      saturated   = (cnt_q == CNT_MAX);
      measured    = saturated ? CNT_MAX : cnt_q + COUNT_W'(1);
      cnt_d       = start_evt ? '0 : measured;
      half        = measured >> 1;
      norm        = kind_half ? ((half == '0) ? COUNT_W'(1) : half) : measured;
      cand_diff   = (norm >= cand_q) ? norm - cand_q : cand_q - norm;
      rate_up     = (norm > rate_q);
      rate_diff   = rate_up ? norm - rate_q : rate_q - norm;
      cand_ok     = (cand_diff <= tol_ext);
      rate_ok     = (rate_diff <= tol_ext);
      norm_x2     = {norm, 1'b0};
      fast_relock = pausable && (norm_x2 <= {1'b0, rate_q});
      timeout_hit = timeout_en && (cnt_q == bus_if.pause_timeout_i);
    end

    // Lane state machine: acquire a stable candidate, track drift, handle loss and pause
    always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_req) begin
        state_q      <= ST_IDLE;
        cnt_q        <= '0;
        cand_q       <= '0;
        cand_valid_q <= 1'b0;
        match_q      <= '0;
        rate_q       <= '0;
        locked_q     <= 1'b0;
        paused_q     <= 1'b0;
        viol_q       <= 1'b0;
        drift_q      <= 1'b0;
        dir_q        <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        viol_q  <= 1'b0;
        drift_q <= 1'b0;
        dir_q   <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (start_evt) begin
              state_q      <= ST_ACQUIRE;
              cand_valid_q <= 1'b0;
              match_q      <= '0;
            end
          end
          ST_ACQUIRE: begin
            if (update_evt) begin
              if (!cand_valid_q || !cand_ok) begin
                cand_q       <= norm;
                cand_valid_q <= 1'b1;
                match_q      <= MATCH_W'(1);
              end else if (match_q == MATCH_LAST) begin
                rate_q   <= cand_q;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end else begin
                match_q <= match_q + MATCH_W'(1);
              end
            end else if (saturated) begin
              cand_valid_q <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (update_evt) begin
              if (rate_ok) begin
                if (rate_diff != '0) begin
                  drift_q <= 1'b1;
                  dir_q   <= rate_up;
                  rate_q  <= rate_up ? rate_q + COUNT_W'(1) : rate_q - COUNT_W'(1);
                end
              end else if (fast_relock) begin
                rate_q <= norm;
              end else begin
                viol_q       <= 1'b1;
                locked_q     <= 1'b0;
                state_q      <= ST_ACQUIRE;
                cand_q       <= norm;
                cand_valid_q <= 1'b1;
                match_q      <= MATCH_W'(1);
              end
            end else if (!start_evt && timeout_hit) begin
              if (pausable) begin
                state_q  <= ST_PAUSED;
                paused_q <= 1'b1;
              end else begin
                viol_q       <= 1'b1;
                locked_q     <= 1'b0;
                state_q      <= ST_ACQUIRE;
                cand_valid_q <= 1'b0;
                match_q      <= '0;
              end
            end
          end
          ST_PAUSED: begin
            if (start_evt) begin
              state_q  <= ST_LOCKED;
              paused_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign bus_if.rate_o[g*COUNT_W +: COUNT_W] = rate_q;
    assign bus_if.locked_o[g]                  = locked_q;
    assign bus_if.paused_o[g]                  = paused_q;
    assign bus_if.violation_o[g]               = viol_q;
    assign bus_if.drift_o[g]                   = drift_q;
    assign bus_if.drift_dir_o[g]               = dir_q;
  end

endmodule

// File: tb/tb_multi_lane_rate_recovery.sv
// tb/tb_multi_lane_rate_recovery.sv - directed and randomized bench with a timestamp-based lane model
module tb_multi_lane_rate_recovery;
  localparam int CH   = 2;
  localparam int CW   = 10;
  localparam int TW   = 8;
  localparam int LC   = 4;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_lane_rate_recovery_if #(.CHANNELS(CH), .COUNT_W(CW), .TOL_W(TW)) bus ();

  multi_lane_rate_recovery #(.CHANNELS(CH), .COUNT_W(CW), .TOL_W(TW), .LOCK_COUNT(LC)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: phase 0 idle, 1 acquiring, 2 locked, 3 paused
  longint t_cyc = 0;
  longint m_t0[CH];
  int     m_phase[CH];
  longint m_cand[CH];
  bit     m_cv[CH];
  int     m_match[CH];
  longint m_rate[CH];
  bit     m_lock[CH], m_paus[CH], m_vio[CH], m_drift[CH], m_dir[CH];

  int dut_vio[CH];
  int dut_drift[CH];
  bit last_dir[CH];

  initial begin
    for (int l = 0; l < CH; l++) begin
      m_t0[l] = 0; m_phase[l] = 0; m_cand[l] = 0; m_cv[l] = 0; m_match[l] = 0; m_rate[l] = 0;
      m_lock[l] = 0; m_paus[l] = 0; m_vio[l] = 0; m_drift[l] = 0; m_dir[l] = 0;
      dut_vio[l] = 0; dut_drift[l] = 0; last_dir[l] = 0;
    end
  end

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Interval = cycles since the last start (or clear); counter value = interval - 1, both saturating.
  task automatic model_lane(input int l);
    bit clr, pz, r, f, st, up;
    int kind, pol;
    longint el, cnt, meas, nrm, d, tol, to;
    clr  = !rst_n || bus.clear_state_i || !bus.enable_i;
    kind = bus.mode_i[1:0];
    pz   = bus.mode_i[2];
    pol  = bus.polarity_i;
    tol  = bus.tolerance_i;
    to   = bus.pause_timeout_i;
    if (clr) begin
      m_phase[l] = 0; m_cand[l] = 0; m_cv[l] = 0; m_match[l] = 0; m_rate[l] = 0;
      m_lock[l] = 0; m_paus[l] = 0; m_vio[l] = 0; m_drift[l] = 0; m_dir[l] = 0;
      m_t0[l] = t_cyc;
      return;
    end
    r = bus.rising_edge_i[l];
    f = bus.falling_edge_i[l];
    if (pol == 1 && kind != 2) begin st = r; up = f; end
    else if (pol == 2 && kind != 2) begin st = f; up = r; end
    else begin st = r | f; up = r | f; end
    el   = t_cyc - m_t0[l];
    cnt  = (el - 1 > CMAX) ? CMAX : el - 1;
    meas = (el > CMAX) ? CMAX : el;
    if (kind == 1 || kind == 2) nrm = (meas / 2 < 1) ? 1 : meas / 2;
    else nrm = meas;
    m_vio[l] = 0; m_drift[l] = 0; m_dir[l] = 0;
    case (m_phase[l])
      0: if (st) begin m_phase[l] = 1; m_cv[l] = 0; end
      1: begin
        if (up) begin
          if (!m_cv[l] || absl(nrm - m_cand[l]) > tol) begin
            m_cand[l] = nrm; m_cv[l] = 1; m_match[l] = 1;
          end else begin
            m_match[l]++;
            if (m_match[l] == LC) begin m_rate[l] = m_cand[l]; m_lock[l] = 1; m_phase[l] = 2; end
          end
        end else if (cnt == CMAX) m_cv[l] = 0;
      end
      2: begin
        if (up) begin
          d = nrm - m_rate[l];
          if (absl(d) <= tol) begin
            if (d != 0) begin m_drift[l] = 1; m_dir[l] = (d > 0); m_rate[l] += (d > 0) ? 1 : -1; end
          end else if (pz && 2 * nrm <= m_rate[l]) begin
            m_rate[l] = nrm;
          end else begin
            m_vio[l] = 1; m_lock[l] = 0; m_phase[l] = 1; m_cand[l] = nrm; m_cv[l] = 1; m_match[l] = 1;
          end
        end else if (!st && to != 0 && cnt == to) begin
          if (pz) begin m_phase[l] = 3; m_paus[l] = 1; end
          else begin m_vio[l] = 1; m_lock[l] = 0; m_phase[l] = 1; m_cv[l] = 0; end
        end
      end
      default: if (st) begin m_phase[l] = 2; m_paus[l] = 0; end
    endcase
    if (st) m_t0[l] = t_cyc;
  endtask

  // Advance the model on the same edge the DUT samples its inputs
  always @(posedge clk) begin
    t_cyc = t_cyc + 1;
    for (int l = 0; l < CH; l++) model_lane(l);
  end

  // Every-cycle comparison of all lane outputs against the model
  always @(negedge clk) begin
    logic [CW+4:0] got, ev;
    for (int l = 0; l < CH; l++) begin
      got = {bus.rate_o[l*CW +: CW], bus.locked_o[l], bus.paused_o[l], bus.violation_o[l],
             bus.drift_o[l], bus.drift_dir_o[l]};
      ev  = {CW'(m_rate[l]), m_lock[l], m_paus[l], m_vio[l], m_drift[l], m_dir[l]};
      n_tests++;
      if (got !== ev) begin
        n_fail++;
        $display("FAIL lane%0d_outputs cycle %0d: got rate=%0d lk/pa/vi/dr/dir=%b, expected rate=%0d lk/pa/vi/dr/dir=%b",
                 l, t_cyc, got[CW+4:5], got[4:0], ev[CW+4:5], ev[4:0]);
      end
      if (bus.violation_o[l] === 1'b1) dut_vio[l]++;
      if (bus.drift_o[l] === 1'b1) begin dut_drift[l]++; last_dir[l] = bus.drift_dir_o[l]; end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dut_rate(input int l);
    return longint'(bus.rate_o[l*CW +: CW]);
  endfunction

  task automatic step(input logic [CH-1:0] r, input logic [CH-1:0] f);
    @(negedge clk);
    #1;
    bus.rising_edge_i  = r;
    bus.falling_edge_i = f;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0);
  endtask

  task automatic edges0(input int n, input int period);
    repeat (n) begin step(2'b01, 2'b00); idle(period - 1); end
  endtask

  task automatic clear_with(input logic [2:0] mode, input logic [1:0] pol, input int tol, input int to);
    bus.mode_i          = mode;
    bus.polarity_i      = pol;
    bus.tolerance_i     = TW'(tol);
    bus.pause_timeout_i = CW'(to);
    bus.clear_state_i   = 1'b1;
    step('0, '0);
    bus.clear_state_i   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, d0;
    logic [CH-1:0] r, f;
    int cd[CH], base[CH];
    bit ph[CH];

    bus.enable_i = 1'b1; bus.clear_state_i = 1'b0; bus.mode_i = 3'b000; bus.polarity_i = 2'b00;
    bus.tolerance_i = TW'(1); bus.pause_timeout_i = '0;
    bus.rising_edge_i = '0; bus.falling_edge_i = '0;
    idle(3);
    chk("reset_rate", longint'(bus.rate_o), 0);
    chk("reset_flags", longint'({bus.locked_o, bus.paused_o, bus.violation_o, bus.drift_o, bus.drift_dir_o}), 0);
    rst_n = 1'b1;
    idle(2);

    // SINGLE lock at period 10
    v0 = dut_vio[0];
    edges0(4, 10);
    step(2'b01, 2'b00);
    chk("t1_not_locked_yet", bus.locked_o[0], 0);
    step('0, '0);
    chk("t1_locked", bus.locked_o[0], 1);
    chk("t1_rate", dut_rate(0), 10);
    chk("t1_model_rate", m_rate[0], 10);
    chk("t1_no_violation", dut_vio[0] - v0, 0);

    // drift up to 11, then a 14 breaks lock
    d0 = dut_drift[0];
    idle(9);
    step(2'b01, 2'b00);
    step('0, '0);
    chk("t2_drift_pulse", dut_drift[0] - d0, 1);
    chk("t2_drift_dir", last_dir[0], 1);
    chk("t2_rate", dut_rate(0), 11);
    v0 = dut_vio[0];
    idle(12);
    step(2'b01, 2'b00);
    step('0, '0);
    chk("t2_violation", dut_vio[0] - v0, 1);
    chk("t2_unlocked", bus.locked_o[0], 0);

    // DIF, pos polarity: lane0 high phase 20, lane1 same-cycle rise/fall every 12
    clear_with(3'b001, 2'b01, 1, 0);
    chk("t3_clear_flags", longint'({bus.locked_o, bus.violation_o}), 0);
    for (int c = 0; c <= 200; c++) begin
      r = {(c % 12 == 0), (c % 40 == 0)};
      f = {(c % 12 == 0), (c % 40 == 20)};
      step(r, f);
    end
    idle(2);
    chk("t3_lane0_rate", dut_rate(0), 10);
    chk("t3_lane0_locked", bus.locked_o[0], 1);
    chk("t3_lane1_rate", dut_rate(1), 6);
    chk("t3_model_lane1_rate", m_rate[1], 6);

    // PAUSABLE timeout 50
    clear_with(3'b100, 2'b00, 1, 50);
    v0 = dut_vio[0];
    edges0(4, 10);
    step(2'b01, 2'b00);
    idle(51);
    chk("t4_not_paused_yet", bus.paused_o[0], 0);
    step('0, '0);
    chk("t4_paused", bus.paused_o[0], 1);
    chk("t4_locked_held", bus.locked_o[0], 1);
    chk("t4_rate_held", dut_rate(0), 10);
    idle(147);
    step(2'b01, 2'b00);
    step('0, '0);
    chk("t4_unpaused", bus.paused_o[0], 0);
    chk("t4_still_locked", bus.locked_o[0], 1);
    chk("t4_no_violation", dut_vio[0] - v0, 0);

    // CONTINUOUS timeout 50
    clear_with(3'b000, 2'b00, 1, 50);
    edges0(5, 10);
    chk("t5_locked_first", bus.locked_o[0], 1);
    v0 = dut_vio[0];
    idle(200);
    chk("t5_violation", dut_vio[0] - v0, 1);
    chk("t5_unlocked", bus.locked_o[0], 0);

    // PAUSABLE fast relock from 20 to 8
    clear_with(3'b100, 2'b00, 1, 0);
    edges0(4, 20);
    step(2'b01, 2'b00);
    idle(7);
    chk("t5_rate20", dut_rate(0), 20);
    v0 = dut_vio[0];
    step(2'b01, 2'b00);
    step('0, '0);
    chk("t5_fast_rate", dut_rate(0), 8);
    chk("t5_model_fast_rate", m_rate[0], 8);
    chk("t5_fast_locked", bus.locked_o[0], 1);
    chk("t5_fast_no_violation", dut_vio[0] - v0, 0);

    // clear mid-acquire and reset while locked
    clear_with(3'b000, 2'b00, 1, 0);
    edges0(3, 10);
    bus.clear_state_i = 1'b1;
    step('0, '0);
    bus.clear_state_i = 1'b0;
    edges0(3, 10);
    chk("t6_no_lock_after_clear", bus.locked_o[0], 0);
    edges0(2, 10);
    chk("t6_relocked", bus.locked_o[0], 1);
    rst_n = 1'b0;
    step('0, '0);
    rst_n = 1'b1;
    chk("t6_reset_rate", longint'(bus.rate_o), 0);
    chk("t6_reset_locked", longint'(bus.locked_o), 0);
    edges0(4, 10);
    chk("t6_not_locked_4", bus.locked_o[0], 0);
    edges0(1, 10);
    chk("t6_locked_5", bus.locked_o[0], 1);

    // randomized epochs
    for (int e = 0; e < 10; e++) begin
      clear_with(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(30, 90) : 0);
      for (int l = 0; l < CH; l++) begin
        base[l] = $urandom_range(3, 25); cd[l] = base[l]; ph[l] = 0;
      end
      for (int c = 0; c < 500; c++) begin
        r = '0; f = '0;
        for (int l = 0; l < CH; l++) begin
          cd[l]--;
          if (cd[l] <= 0) begin
            if ($urandom_range(0, 9) == 0) begin r[l] = 1'b1; f[l] = 1'b1; end
            else if (ph[l]) f[l] = 1'b1;
            else r[l] = 1'b1;
            ph[l] = ~ph[l];
            if ($urandom_range(0, 39) == 0) cd[l] = $urandom_range(60, 160);
            else cd[l] = base[l] + $urandom_range(0, 2) - 1;
            if (cd[l] < 1) cd[l] = 1;
          end
        end
        if (e == 3 && c == 250) bus.enable_i = 1'b0;
        if (e == 3 && c == 256) bus.enable_i = 1'b1;
        step(r, f);
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_lane_rate_recovery.md
Name: multi_lane_rate_recovery

Overview:
Parametrised, multi-channel successor to the single-lane rate recovery path. Each channel measures the interval between qualified edges from the upstream edge detector, locks onto a stable rate, then tracks slow drift with a slew limit. Each channel detects violations and pauses, and supports SINGLE/DIF/QUAD and CONTINUOUS/PAUSABLE modes. Sits between the edge-detect stage and the clock/data regeneration stage; all channels share one mode configuration.

Parameters:
CHANNELS, 2, number of independent recovery lanes
COUNT_W, 16, interval counter and rate width
TOL_W, 8, tolerance field width
LOCK_COUNT, 4, consecutive in-tolerance samples required to lock (>=2)

Ports:
sys_dom_i.clk  input  1  single system clock
sys_dom_i.rst_n  input  1  synchronous, active-low reset
enable_i  input  1  global enable; low behaves as clear_state_i held
clear_state_i  input  1  one-cycle synchronous clear of all lanes
mode_i  input  3  {pausable, kind[1:0]}; kind 00 SINGLE, 01 DIF, 10 QUAD, 11 reserved (treated as SINGLE)
polarity_i  input  2  00 disabled, 01 pos, 10 neg, 11 treated as disabled
tolerance_i  input  TOL_W  allowed |sample - rate| in cycles, zero-extended
pause_timeout_i  input  COUNT_W  idle cycles before pause/loss; 0 disables timeout
rising_edge_i  input  CHANNELS  per-lane rising-edge strobe
falling_edge_i  input  CHANNELS  per-lane falling-edge strobe
rate_o  output  CHANNELS*COUNT_W  per-lane recovered rate, lane n at [n*COUNT_W +: COUNT_W]
locked_o  output  CHANNELS  lane locked
paused_o  output  CHANNELS  lane in PAUSED
violation_o  output  CHANNELS  one-cycle violation pulse
drift_o  output  CHANNELS  one-cycle drift-correction pulse
drift_dir_o  output  CHANNELS  1 = rate increased, 0 = decreased; valid with drift_o

Behaviour:
- Reset and clear: every output 0; all lane state to IDLE; counters and candidates 0.
- Event selection per lane: any = rise|fall.
  - Polarity disabled, or kind QUAD: start = update = any.
  - Pos: start = rise, update = fall.
  - Neg: start = fall, update = rise.
- Counter: cnt_next = start ? 0 : saturating(cnt+1), saturating at 2^COUNT_W-1.
  - On update, measured = cnt+1. Example: edges at cycles 0 and 10 give measured 10.
  - Same-cycle start and update: sample first, then restart.
- Normalisation: norm = measured for SINGLE; norm = max(measured>>1, 1) for DIF/QUAD.
- Lane FSM:
  - IDLE: first start event with enable_i high -> ACQUIRE (candidate invalid).
  - ACQUIRE, update with candidate invalid: candidate = norm, match = 1.
  - ACQUIRE, |norm-candidate| <= tol: match++. When match reaches LOCK_COUNT: rate_o = candidate, locked_o = 1 -> LOCKED.
  - ACQUIRE, out of tolerance: candidate = norm, match = 1, no violation.
  - ACQUIRE, counter saturation: candidate invalidated.
  - LOCKED, diff = norm - rate_o, |diff| <= tol, diff != 0: rate_o moves 1 toward norm; drift_o pulse with direction (slew limit 1/sample).
  - LOCKED, diff = 0: no action.
  - LOCKED, pausable and 2*norm <= rate_o: rate_o = norm immediately, stay locked, no violation (faster relock).
  - LOCKED, any other out-of-tolerance sample: violation_o pulse, locked_o = 0 -> ACQUIRE with candidate = norm, match = 1.
  - LOCKED, pause_timeout_i != 0 and cnt reaches pause_timeout_i:
    - Pausable: -> PAUSED, paused_o = 1, locked_o and rate_o held.
    - Continuous: violation_o pulse, locked_o = 0 -> ACQUIRE with candidate invalid.
  - PAUSED: the next start event clears paused_o -> LOCKED. An update arriving without a start (pos/neg) is ignored.
- Outputs are registered: state and output changes appear one cycle after the qualifying strobe.
- Lanes are fully independent; configuration inputs are sampled every cycle.
- Mode or polarity change while locked: software must pulse clear_state_i; otherwise behaviour is undefined.

Test Plan:
- SINGLE, polarity disabled, tol=1, LOCK_COUNT=4, lane0 edges every 10 cycles -> locked_o[0] rises 1 cycle after the 4th sample; rate_o[0] = 10; no violation.
- Locked at 10, then period 11 -> drift_o pulse with drift_dir_o = 1, rate_o = 11. Then period 14 -> violation_o pulse, locked_o = 0.
- DIF, pos polarity, high phase 20 -> rate_o = 10. Same-cycle rise/fall on lane1 -> sample taken, then restart; lane0 unaffected.
- PAUSABLE, locked at 10, timeout=50, 200 idle cycles -> paused_o = 1 at cnt = 50 with rate held; next edge -> paused_o = 0, locked_o stays 1.
- CONTINUOUS, same 200-cycle gap -> violation_o pulse at timeout, locked_o = 0. PAUSABLE locked at 20 with period 8 -> rate_o = 8 and no violation.
- clear_state_i pulse mid-ACQUIRE, and rst_n low while locked -> all outputs 0 next cycle; relock requires a fresh LOCK_COUNT samples.
